pin_entry_driver: RTL

- Transmit side of the PIN-entry interface. Accepts an 8-bit PIN word and serialises it into four 2-bit digit/submit strobes toward the pin checker, MSB digit first.
- Waits for the checker's correct/incorrect result and reports pass, fail or timeout.
- Counts consecutive failures and enforces a lockout period.
- Sits between the host/test sequencer and the pin checker.

---
 rtl/pin_pkg.sv | 28 ++
 rtl/pin_timer.sv | 26 ++
 rtl/pin_entry_driver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pin_pkg.sv
// Shared types and constants for the PIN-entry driver and the checker bench.
package pin_pkg;

  localparam int unsigned PIN_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 2;
  localparam int unsigned PIN_W      = PIN_DIGITS * DIGIT_W;

  localparam logic [PIN_W-1:0] DEFAULT_PASSKEY = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StReady,
    StSend,
    StGap,
    StAwait,
    StClear,
    StLocked
  } state_t;

  // Digit idx of a PIN word, counting from the most significant digit.
  function automatic logic [DIGIT_W-1:0] pin_digit(input logic [PIN_W-1:0] word,
                                                   input logic [1:0]       idx);
    logic [PIN_W-1:0] shifted;
    shifted = word << (DIGIT_W * 32'(idx));
    return shifted[PIN_W-1 -: DIGIT_W];
  endfunction

endpackage

// File: rtl/pin_timer.sv
// Loadable down-counter; expired stays high while the count rests at zero.
module pin_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/pin_entry_driver.sv
// Serialises a PIN word into digit strobes for the pin checker, collects the verdict and
// enforces a lockout after repeated failures.
module pin_entry_driver
  import pin_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCK_CYCLES    = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PIN_W-1:0]   pin,
  input  logic               chk_waiting,
  input  logic               chk_correct,
  input  logic               chk_incorrect,
  output logic [DIGIT_W-1:0] digit,
  output logic               submit,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic               locked,
  output logic [1:0]         fail_count
);

  localparam int unsigned MaxGt     = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned MaxCycles = (MaxGt > LOCK_CYCLES) ? MaxGt : LOCK_CYCLES;
  localparam int unsigned TW        = $clog2(MaxCycles);
  localparam logic [1:0]  FailLimit = 2'(MAX_FAILS);
  localparam logic [1:0]  LastDigit = 2'(PIN_DIGITS - 1);

  state_t           state;
  logic [PIN_W-1:0] pin_word;
  logic [1:0]       idx;
  logic             tmr_load;
  logic [TW-1:0]    tmr_value;
  logic             tmr_expired;

  pin_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .value  (tmr_value),
    .expired(tmr_expired)
  );

  // The timer is preloaded for whichever waiting state comes next; the count then starts on
  // the first cycle of that state so expiry lands on its last cycle.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      StIdle: begin
        tmr_load  = 1'b1;
        tmr_value = TW'(TIMEOUT_CYCLES - 1);
      end
      StSend: begin
        tmr_load  = 1'b1;
        tmr_value = (idx == LastDigit) ? TW'(TIMEOUT_CYCLES - 1) : TW'(GAP_CYCLES - 2);
      end
      StClear: begin
        tmr_load  = 1'b1;
        tmr_value = TW'(LOCK_CYCLES - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      pin_word   <= '0;
      idx        <= '0;
      digit      <= '0;
      submit     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      locked     <= 1'b0;
      fail_count <= '0;
    end else begin
      submit <= 1'b0;
      done   <= 1'b0;
      case (state)
        StIdle: begin
          if (start && !locked) begin
            pin_word <= pin;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            busy     <= 1'b1;
            state    <= StReady;
          end
        end
        StReady: begin
          if (chk_waiting) begin
            idx    <= '0;
            digit  <= pin_digit(pin_word, 2'd0);
            submit <= 1'b1;
            state  <= StSend;
          end else if (tmr_expired) begin
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
            state   <= StClear;
          end
        end
        StSend: begin
          state <= (idx == LastDigit) ? StAwait : StGap;
        end
        StGap: begin
          if (tmr_expired) begin
            idx    <= idx + 2'd1;
            digit  <= pin_digit(pin_word, idx + 2'd1);
            submit <= 1'b1;
            state  <= StSend;
          end
        end
        StAwait: begin
          if (chk_correct) begin
            pass       <= 1'b1;
            fail_count <= '0;
            done       <= 1'b1;
            state      <= StClear;
          end else if (chk_incorrect) begin
            pass <= 1'b0;
            if (fail_count != FailLimit) fail_count <= fail_count + 2'd1;
            done  <= 1'b1;
            state <= StClear;
          end else if (tmr_expired) begin
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
            state   <= StClear;
          end
        end
        StClear: begin
          // The checker holds its verdict for several cycles; let it drop first.
          if (!chk_correct && !chk_incorrect) begin
            busy <= 1'b0;
            if (fail_count == FailLimit) begin
              locked <= 1'b1;
              state  <= StLocked;
            end else begin
              state <= StIdle;
            end
          end
        end
        StLocked: begin
          if (tmr_expired) begin
            locked     <= 1'b0;
            fail_count <= '0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
